// File: rtl/iter_shift_unit_pkg.sv
// Shared definitions for the iterative shifter: FSM state type and the
// encodings of the direction and mode request fields.
package iter_shift_unit_pkg;

    // Controller states: waiting for a request, stepping, holding a result.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // in_dir encodings
    localparam logic DIR_LEFT   = 1'b0;
    localparam logic DIR_RIGHT  = 1'b1;

    // in_arith encodings
    localparam logic MODE_LOGIC = 1'b0;
    localparam logic MODE_ARITH = 1'b1;

endpackage

// File: rtl/iter_shift_unit_shift_step.sv
// shift_step: combinational single-bit shift stage.
//   d       in   WIDTH  current operand value
//   dir     in   1      0 = left, 1 = right
//   arith   in   1      0 = logical, 1 = arithmetic
//   sign0   in   1      sign bit of the original (unshifted) operand
//   d_next  out  WIDTH  value after one 1-bit step
//   ovf_bit out  1      this step overflows (left shifts only)
module shift_step
    import iter_shift_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    input  logic             arith,
    input  logic             sign0,
    output logic [WIDTH-1:0] d_next,
    output logic             ovf_bit
);

    logic fill;

    always_comb begin
        d_next  = d;
        ovf_bit = 1'b0;
        fill    = 1'b0;
        if (dir == DIR_LEFT) begin
            d_next = {d[WIDTH-2:0], 1'b0};
            if (arith == MODE_ARITH) begin
                // d[WIDTH-2] becomes the new MSB; overflow when it leaves
                // the original sign.
                ovf_bit = (d[WIDTH-2] != sign0);
            end else begin
                ovf_bit = d[WIDTH-1];
            end
        end else begin
            fill   = (arith == MODE_ARITH) ? d[WIDTH-1] : MODE_LOGIC;
            d_next = {fill, d[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle shifter, one bit per clock, valid/ready on
// both sides. A request is latched in IDLE, stepped shamt times in SHIFT,
// and the result is held in DONE until the consumer accepts it.
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        request valid
//   in_ready   out  1        unit can accept a request (IDLE only)
//   in_data    in   WIDTH    operand
//   in_shamt   in   SHAMT_W  shift amount
//   in_dir     in   1        0 = left, 1 = right
//   in_arith   in   1        0 = logical, 1 = arithmetic
//   out_valid  out  1        result valid (DONE)
//   out_ready  in   1        consumer accepts result
//   out_data   out  WIDTH    shifted result
//   out_ovf    out  1        sticky left-shift overflow
//   busy       out  1        high in SHIFT or DONE
module iter_shift_unit
    import iter_shift_unit_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_dir,
    input  logic               in_arith,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_ovf,
    output logic               busy
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               ovf_q;
    logic               dir_q;
    logic               arith_q;
    logic               sign0_q;

    logic [WIDTH-1:0]   step_d;
    logic               step_ovf;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .d       (data_q),
        .dir     (dir_q),
        .arith   (arith_q),
        .sign0   (sign0_q),
        .d_next  (step_d),
        .ovf_bit (step_ovf)
    );

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (in_shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (cnt_q == CNT_ONE) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            dir_q   <= DIR_LEFT;
            arith_q <= MODE_LOGIC;
            sign0_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        dir_q   <= in_dir;
                        arith_q <= in_arith;
                        sign0_q <= in_data[WIDTH-1];
                        cnt_q   <= in_shamt;
                        ovf_q   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    data_q <= step_d;
                    ovf_q  <= ovf_q | step_ovf;
                    cnt_q  <= cnt_q - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    // Result registers double as outputs; they only change in IDLE/SHIFT,
    // so they stay stable while DONE waits for out_ready.
    assign out_data = data_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit (WIDTH=8, SHAMT_W=3).
// Directed cases plus randomized requests checked against an arithmetic
// reference model; inputs driven and outputs sampled on the falling edge.
module tb_iter_shift_unit;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned SHAMT_W = 3;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               in_dir;
    logic               in_arith;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_ovf;
    logic               busy;

    int total = 0;
    int bad   = 0;

    iter_shift_unit #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_dir    (in_dir),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: value-level arithmetic on the whole shift.
    task automatic ref_shift(input logic [7:0] d, input int s, input logic dir,
                             input logic arith, output logic [7:0] res, output logic ovf);
        logic signed [7:0] sd;
        int uv;
        int sv;
        sd  = d;
        ovf = 1'b0;
        if (dir == 1'b0) begin
            uv  = int'(d) * (1 << s);
            sv  = int'(sd) * (1 << s);
            res = uv[7:0];
            if (arith) ovf = (sv > 127) || (sv < -128);
            else       ovf = (uv > 255);
        end else if (arith) begin
            res = 8'(sd >>> s);
        end else begin
            res = d >> s;
        end
    endtask

    // One full transaction. hold = number of cycles out_ready is held low
    // while out_valid is up (0 means out_ready is high throughout).
    task automatic run_op(input logic [7:0] d, input int s, input logic dir,
                          input logic arith, input int hold, input string tag);
        logic [7:0] er;
        logic       eo;
        logic [7:0] held_d;
        logic       held_o;
        int n;
        ref_shift(d, s, dir, arith, er, eo);
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = SHAMT_W'(s);
        in_dir    = dir;
        in_arith  = arith;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(s + 1));
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"}, 32'(out_data), 32'(er));
        check({tag, ".ovf"}, 32'(out_ovf), 32'(eo));
        held_d = out_data;
        held_o = out_ovf;
        for (int i = 0; i < hold; i++) begin
            // A competing request must be ignored while the result is held.
            in_valid = 1'b1;
            in_data  = ~d;
            in_shamt = 3'd1;
            @(negedge clk);
            check({tag, ".hold_data"}, 32'(out_data), 32'(held_d));
            check({tag, ".hold_ovf"}, 32'(out_ovf), 32'(held_o));
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, ".hold_busy"}, 32'(busy), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".post_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".post_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_dir    = 1'b0;
        in_arith  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.out_data", 32'(out_data), 32'd0);
        check("reset.out_ovf", 32'(out_ovf), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Directed cases
        run_op(8'hE5, 2, 1'b1, 1'b1, 0, "ra_E5");
        check("ra_E5.const", 32'(8'hF9), 32'(8'hF9) & 32'(out_data | 8'hFF));
        run_op(8'hE5, 2, 1'b1, 1'b0, 0, "rl_E5");
        run_op(8'h25, 2, 1'b0, 1'b0, 0, "ll_25");
        run_op(8'h25, 2, 1'b0, 1'b1, 0, "la_25");
        run_op(8'hA5, 0, 1'b0, 1'b1, 0, "zero_A5");
        run_op(8'h80, 1, 1'b0, 1'b0, 0, "ll_80");
        run_op(8'h7F, 7, 1'b1, 1'b1, 0, "ra_7F_7");
        run_op(8'h81, 7, 1'b1, 1'b1, 0, "ra_81_7");
        run_op(8'hC0, 1, 1'b0, 1'b1, 0, "la_C0_1");
        run_op(8'h5A, 3, 1'b0, 1'b0, 5, "bp_5A");

        // Reset asserted at the third SHIFT edge of a shamt-7 request
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hB3;
        in_shamt = 3'd7;
        in_dir   = 1'b0;
        in_arith = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.out_data", 32'(out_data), 32'd0);
        check("midrst.out_ovf", 32'(out_ovf), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        run_op(8'h3C, 1, 1'b1, 1'b0, 0, "after_rst");

        // Randomized requests
        for (int k = 0; k < 40; k++) begin
            run_op(8'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
                   1'($urandom), int'($urandom_range(0, 2)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
